// File: rtl/rv_enc_pkg.sv
// Shared definitions for the RV32I (+MEMCPY) instruction encoder/loader:
// opcode values, instruction formats, loader states and immediate range limits.
package rv_enc_pkg;

    // Opcode values mirror the core's controls.sv TYPE_* macros.
    localparam logic [6:0] OPC_COMP   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_MEMCPY = 7'b0001011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_I_SHR, FMT_S, FMT_SB, FMT_U, FMT_UJ, FMT_MEMCPY
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE, ST_ARMED, ST_WRITE
    } state_e;

    localparam int I_MIN      = -2048;
    localparam int I_MAX      = 2047;
    localparam int SB_MIN     = -4096;
    localparam int SB_MAX     = 4094;
    localparam int UJ_MIN     = -(1 << 20);
    localparam int UJ_MAX     = (1 << 20) - 2;
    localparam int SHAMT_MAX  = 31;
    localparam int MEMCPY_MAX = 127;

    function automatic fmt_e opcode_fmt(input logic [6:0] opc, input logic [2:0] f3);
        fmt_e f;
        case (opc)
            OPC_COMP:            f = (f3 == 3'b101) ? FMT_I_SHR : FMT_I;
            OPC_LOAD, OPC_JALR:  f = FMT_I;
            OPC_STORE:           f = FMT_S;
            OPC_BRANCH:          f = FMT_SB;
            OPC_LUI, OPC_AUIPC:  f = FMT_U;
            OPC_JAL:             f = FMT_UJ;
            OPC_MEMCPY:          f = FMT_MEMCPY;
            default:             f = FMT_R;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational field packer: decoded fields -> 32-bit instruction word plus an
// immediate-legality flag. Range checking is compiled in with IMM_RANGE_CHECK_EN.
module inst_pack
    import rv_enc_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        imm_ok
);

    fmt_e fmt;
    assign fmt = opcode_fmt(opcode, func3);

    // Start from the R layout and overwrite only the bits that carry the immediate.
    always_comb begin
        word = {func7, rs2, rs1, func3, rd, opcode};
        case (fmt)
            FMT_I:      word[31:20] = imm[11:0];
            FMT_I_SHR:  word[24:20] = imm[4:0];
            FMT_S: begin
                word[31:25] = imm[11:5];
                word[11:7]  = imm[4:0];
            end
            FMT_SB: begin
                word[31]    = imm[12];
                word[30:25] = imm[10:5];
                word[11:8]  = imm[4:1];
                word[7]     = imm[11];
            end
            FMT_U:      word[31:12] = imm[31:12];
            FMT_UJ: begin
                word[31]    = imm[20];
                word[30:21] = imm[10:1];
                word[20]    = imm[11];
                word[19:12] = imm[19:12];
            end
            FMT_MEMCPY: word[31:25] = imm[6:0];
            default: ;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic signed [31:0] simm;
    assign simm = $signed(imm);

    always_comb begin
        imm_ok = 1'b1;
        case (fmt)
            FMT_I, FMT_S: imm_ok = (simm >= I_MIN) && (simm <= I_MAX);
            FMT_I_SHR:    imm_ok = (simm >= 0) && (simm <= SHAMT_MAX);
            FMT_SB:       imm_ok = (simm >= SB_MIN) && (simm <= SB_MAX) && !imm[0];
            FMT_UJ:       imm_ok = (simm >= UJ_MIN) && (simm <= UJ_MAX) && !imm[0];
            FMT_U:        imm_ok = (imm[11:0] == 12'd0);
            FMT_MEMCPY:   imm_ok = (simm >= 0) && (simm <= MEMCPY_MAX);
            default:      imm_ok = 1'b1;
        endcase
    end
`else
    assign imm_ok = 1'b1;
`endif

endmodule

// File: rtl/inst_encoder_loader.sv
// Program loader: encodes field bundles and writes them to instruction memory at
// incrementing addresses. Optional immediate checking via IMM_RANGE_CHECK_EN.
module inst_encoder_loader
    import rv_enc_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_done,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [6:0]        req_opcode,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_func3,
    input  logic [6:0]        req_func7,
    input  logic [31:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              imm_err,
    output state_e            dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e      state, state_nxt;
    logic [31:0] word;
    logic        imm_ok;
    logic        accept;

    inst_pack u_pack (
        .opcode (req_opcode),
        .rd     (req_rd),
        .rs1    (req_rs1),
        .rs2    (req_rs2),
        .func3  (req_func3),
        .func7  (req_func7),
        .imm    (req_imm),
        .word   (word),
        .imm_ok (imm_ok)
    );

    // Handshake: a bundle transfers on a rising edge where req_valid && req_ready;
    // req_ready drops while load_done is high so end-of-program always wins.
    assign req_ready = (state == ST_ARMED) && !load_done;
    assign accept    = req_valid && req_ready;
    assign imem_we   = (state == ST_WRITE);
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (load_start) state_nxt = ST_ARMED;
            ST_ARMED: begin
                if (load_done)             state_nxt = ST_IDLE;
                else if (accept && imm_ok) state_nxt = ST_WRITE;
            end
            ST_WRITE: state_nxt = (imem_addr == LAST_ADDR) ? ST_IDLE : ST_ARMED;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
            full       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && load_start) begin
                imem_addr <= start_addr;
                count     <= '0;
                full      <= 1'b0;
            end
            if (accept && imm_ok) imem_wdata <= word;
            if (state == ST_WRITE) begin
                imem_addr <= imem_addr + 1'b1;
                count     <= count + 1'b1;
                if (imem_addr == LAST_ADDR) full <= 1'b1;
            end
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset)                                  imm_err <= 1'b0;
        else if (state == ST_IDLE && load_start)    imm_err <= 1'b0;
        else if (accept && !imm_ok)                 imm_err <= 1'b1;
    end
`else
    assign imm_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Self-checking bench for inst_encoder_loader: directed encodings, randomized legal
// bundles against an arithmetic reference encoder, boundary and reset scenarios.
module tb_inst_encoder_loader;
    import rv_enc_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk, reset, load_start, load_done, req_valid, req_ready;
    logic [ADDR_W-1:0] start_addr, imem_addr;
    logic [6:0]        req_opcode, req_func7;
    logic [4:0]        req_rd, req_rs1, req_rs2;
    logic [2:0]        req_func3;
    logic [31:0]       req_imm, imem_wdata;
    logic              imem_we, busy, full, imm_err;
    logic [ADDR_W:0]   count;
    state_e            dbg_state;

    inst_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_done(load_done),
        .start_addr(start_addr), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_func3(req_func3), .req_func7(req_func7), .req_imm(req_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .count(count), .full(full), .imm_err(imm_err), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [39:0] exp_q[$];
    int m_addr, m_count;
    bit m_full, m_err;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoder built from the instruction formats with shifts and masks.
    function automatic logic [31:0] enc_ref(input logic [6:0] op, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input int imm);
        logic [31:0] u, o, d, c, a, b, g, w;
        u = imm;
        o = {25'b0, op};
        d = {27'b0, rd} << 7;
        c = {29'b0, f3} << 12;
        a = {27'b0, rs1} << 15;
        b = {27'b0, rs2} << 20;
        g = {25'b0, f7} << 25;
        case (op)
            OPC_COMP, OPC_LOAD, OPC_JALR:
                if (op == OPC_COMP && f3 == 3'd5) w = o | d | c | a | ((u & 32'd31) << 20) | g;
                else                              w = o | d | c | a | ((u & 32'hFFF) << 20);
            OPC_STORE:  w = o | c | a | b | ((u & 32'd31) << 7) | (((u >> 5) & 32'd127) << 25);
            OPC_BRANCH: w = o | c | a | b | (((u >> 11) & 32'd1) << 7) | (((u >> 1) & 32'd15) << 8)
                            | (((u >> 5) & 32'd63) << 25) | (((u >> 12) & 32'd1) << 31);
            OPC_LUI, OPC_AUIPC: w = o | d | (u & 32'hFFFFF000);
            OPC_JAL:    w = o | d | (((u >> 12) & 32'd255) << 12) | (((u >> 11) & 32'd1) << 20)
                            | (((u >> 1) & 32'd1023) << 21) | (((u >> 20) & 32'd1) << 31);
            OPC_MEMCPY: w = o | d | c | a | b | ((u & 32'd127) << 25);
            default:    w = o | d | c | a | b | g;
        endcase
        return w;
    endfunction

    // Immediate generator model (what the core recovers from a word).
    function automatic int immgen_ref(input logic [31:0] w, input logic [6:0] op, input logic [2:0] f3);
        int s;
        s = int'($signed(w));
        case (op)
            OPC_COMP, OPC_LOAD, OPC_JALR:
                if (op == OPC_COMP && f3 == 3'd5) return int'({27'b0, w[24:20]});
                else                              return s >>> 20;
            OPC_STORE:  return ((s >>> 25) <<< 5) | int'({27'b0, w[11:7]});
            OPC_BRANCH: return ((s >>> 31) <<< 12) | int'({20'b0, w[7], w[30:25], w[11:8], 1'b0});
            OPC_LUI, OPC_AUIPC: return int'(w & 32'hFFFFF000);
            OPC_JAL:    return ((s >>> 31) <<< 20) | int'({12'b0, w[19:12], w[20], w[30:21], 1'b0});
            OPC_MEMCPY: return int'({25'b0, w[31:25]});
            default:    return 0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_write", {39'b0, imem_we}, 40'h0);
            else check("write_addr_data", {imem_addr, imem_wdata}, exp_q.pop_front());
        end
    end

    task automatic start_load(input int a);
        @(negedge clk);
        load_start = 1'b1;
        start_addr = ADDR_W'(a);
        @(negedge clk);
        load_start = 1'b0;
        m_addr = a; m_count = 0; m_full = 0; m_err = 0;
    endtask

    // Returns #1 after the accepting edge, i.e. inside the write cycle.
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input int imm, input bit expect_write, input bit check_rt);
        int waited = 0;
        @(negedge clk);
        req_valid = 1'b1; req_opcode = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_func3 = f3; req_func7 = f7; req_imm = imm;
        while (req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready !== 1'b1) begin
            check("ready_timeout", {39'b0, req_ready}, 40'h1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (expect_write) begin
            exp_q.push_back({m_addr[7:0], enc_ref(op, rd, rs1, rs2, f3, f7, imm)});
            m_full = (m_addr == DEPTH - 1);
            m_addr = (m_addr + 1) % DEPTH;
            m_count++;
            if (check_rt) check("roundtrip_imm", immgen_ref(imem_wdata, op, f3), imm);
        end else begin
            m_err = 1;
        end
    endtask

    task automatic end_load();
        int n = 0;
        @(negedge clk);
        while (dbg_state != ST_ARMED && n < 10) begin
            @(negedge clk);
            n++;
        end
        load_done = 1'b1;
        @(negedge clk);
        load_done = 1'b0;
        check("busy_after_done", {39'b0, busy}, 40'h0);
    endtask

    task automatic check_status();
        bit exp_err;
`ifdef IMM_RANGE_CHECK_EN
        exp_err = m_err;
`else
        exp_err = 0;
`endif
        check("count", count, m_count);
        check("full", {39'b0, full}, {39'b0, m_full});
        check("imm_err", {39'b0, imm_err}, {39'b0, exp_err});
        check("addr", imem_addr, m_addr[7:0]);
    endtask

    task automatic send_random();
        logic [6:0] ops[10] = '{OPC_COMP, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH,
                                OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MEMCPY, OPC_RTYPE};
        logic [6:0] op, f7;
        logic [2:0] f3;
        int imm;
        op  = ops[$urandom_range(0, 9)];
        f3  = 3'($urandom_range(0, 7));
        f7  = 7'($urandom_range(0, 127));
        case (op)
            OPC_COMP: begin
                if (f3 == 3'd5) begin
                    imm = int'($urandom_range(0, 31));
                    f7  = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
                end else imm = int'($urandom_range(0, 4095)) - 2048;
            end
            OPC_LOAD, OPC_JALR, OPC_STORE: imm = int'($urandom_range(0, 4095)) - 2048;
            OPC_BRANCH:          imm = 2 * int'($urandom_range(0, 4095)) - 4096;
            OPC_LUI, OPC_AUIPC:  imm = int'($urandom() & 32'hFFFFF000);
            OPC_JAL:             imm = 2 * int'($urandom_range(0, (1 << 20) - 1)) - (1 << 20);
            OPC_MEMCPY:          imm = int'($urandom_range(0, 127));
            default:             imm = int'($urandom());
        endcase
        send(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             f3, f7, imm, 1'b1, op != OPC_RTYPE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load_start = 1'b0; load_done = 1'b0; start_addr = '0;
        req_valid = 1'b0; req_opcode = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        req_func3 = '0; req_func7 = '0; req_imm = '0;
        m_addr = 0; m_count = 0; m_full = 0; m_err = 0;
        repeat (3) @(negedge clk);
        check("rst_ready", {39'b0, req_ready}, 40'h0);
        check("rst_we", {39'b0, imem_we}, 40'h0);
        check("rst_busy", {39'b0, busy}, 40'h0);
        check("rst_wdata", {8'b0, imem_wdata}, 40'h0);
        check_status();
        reset = 1'b0;

        // addi x1,x0,-1
        start_load(0);
        send(OPC_COMP, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -1, 1'b1, 1'b1);
        check("addi_we_latency", {39'b0, imem_we}, 40'h1);
        check("addi_addr", imem_addr, 40'h0);
        check("addi_word", imem_wdata, 40'hFFF00093);
        end_load();
        check_status();

        // beq x1,x2,-4
        start_load(4);
        send(OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -4, 1'b1, 1'b1);
        check("beq_word", imem_wdata, 40'hFE208EE3);
        end_load();

        // jal x1,+2048 then lui x5; a stray load_start while armed is ignored
        start_load(20);
        send(OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 2048, 1'b1, 1'b1);
        check("jal_word", imem_wdata, 40'h001000EF);
        @(negedge clk);
        load_start = 1'b1; start_addr = 8'd99;
        @(negedge clk);
        load_start = 1'b0;
        send(OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 1'b1);
        check("lui_word", imem_wdata, 40'h123452B7);
        check("lui_addr", imem_addr, 40'd21);
        end_load();
        check_status();

        // addi imm=4096: rejected with the check, silently truncated without it
        start_load(30);
`ifdef IMM_RANGE_CHECK_EN
        send(OPC_COMP, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 4096, 1'b0, 1'b0);
        check("illegal_no_we", {39'b0, imem_we}, 40'h0);
        check("illegal_err", {39'b0, imm_err}, 40'h1);
`else
        send(OPC_COMP, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 4096, 1'b1, 1'b0);
`endif
        send(OPC_COMP, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 100, 1'b1, 1'b1);
        end_load();
        check_status();

        // randomized legal bundles
        start_load(int'($urandom_range(0, 100)));
        for (int i = 0; i < 40; i++) send_random();
        end_load();
        check_status();

        // load_done and req_valid together: done wins
        start_load(5);
        @(negedge clk);
        req_valid = 1'b1; load_done = 1'b1;
        #1 check("done_wins_ready", {39'b0, req_ready}, 40'h0);
        @(negedge clk);
        req_valid = 1'b0; load_done = 1'b0;
        check("done_wins_busy", {39'b0, busy}, 40'h0);
        check_status();

        // last-address boundary
        start_load(DEPTH - 2);
        send_random();
        send_random();
        @(negedge clk);
        req_valid = 1'b1;
        @(negedge clk);
        check("full_third_ready", {39'b0, req_ready}, 40'h0);
        check("full_busy", {39'b0, busy}, 40'h0);
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        check_status();

        // reset during a write cycle
        start_load(10);
        send(OPC_STORE, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, -8, 1'b1, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_write_we", {39'b0, imem_we}, 40'h0);
        check("rst_write_busy", {39'b0, busy}, 40'h0);
        check("rst_write_count", count, 40'h0);
        @(negedge clk);
        reset = 1'b0;
        m_addr = 0; m_count = 0; m_full = 0; m_err = 0;
        repeat (4) @(negedge clk);
        check_status();
        check("queue_drained", exp_q.size(), 40'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
